// File: rtl/gpu_fetch_unit.sv
// Instruction fetch stage: issues imem requests, queues returned words with their PC for decode.
// Optional GPU_FETCH_JMP_PREDECODE_EN: JMP words are consumed here as internal redirects.
module gpu_fetch_unit #(
    parameter int PC_WIDTH   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_pc,
    input  logic                halt,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req_valid,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [PC_WIDTH-1:0] inst_pc,
    input  logic                inst_ready,
    output logic                busy,
    output logic [1:0]          dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Handshakes: a transfer happens in a cycle where valid && ready are both high
    // at the rising edge; valid never depends combinationally on the matching ready.
    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] pc, pc_nx;
    logic [PC_WIDTH-1:0] rsp_pc, rsp_pc_nx;
    logic [CW-1:0]       outstanding, out_nx;
    logic [CW-1:0]       drop_cnt, drop_nx;
    logic [CW-1:0]       count, count_nx;
    logic [PW-1:0]       rd_ptr, rd_nx, wr_ptr, wr_nx;
    logic [31:0]         q_inst [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] q_pc   [FIFO_DEPTH];

    logic run, credit, halt_run, ext_redir, acc, rsp_live, rsp_keep;
    logic jmp_hit, flush, push, pop;

    always_comb begin
        run       = (state == S_RUN);
        credit    = ({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(FIFO_DEPTH);
        halt_run  = run && halt;
        ext_redir = run && redirect_valid && !halt;
        // The redirect/halt cycle issues nothing so the next request is already on the new path.
        imem_req_valid = run && credit && !halt && !redirect_valid;
        imem_req_addr  = pc;
        acc       = imem_req_valid && imem_req_ready;
        rsp_live  = imem_rsp_valid && (outstanding != '0);
        rsp_keep  = rsp_live && run && (drop_cnt == '0);
`ifdef GPU_FETCH_JMP_PREDECODE_EN
        jmp_hit   = rsp_keep && (imem_rsp_data[31:28] == 4'b0111) && !ext_redir && !halt;
`else
        jmp_hit   = 1'b0;
`endif
        flush     = halt_run || ext_redir || jmp_hit;
        push      = rsp_keep && !flush;
        pop       = inst_valid && inst_ready;
        out_nx    = outstanding + CW'(acc) - CW'(rsp_live);
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        rsp_pc_nx = rsp_pc;
        drop_nx   = drop_cnt;
        count_nx  = count + CW'(push) - CW'(pop);
        wr_nx     = wr_ptr + PW'(push);
        rd_nx     = rd_ptr + PW'(pop);
        if (rsp_live && (drop_cnt != '0))
            drop_nx = drop_cnt - CW'(1);
        if (push)
            rsp_pc_nx = rsp_pc + PC_WIDTH'(1);
        if (acc)
            pc_nx = pc + PC_WIDTH'(1);
        if (flush) begin
            // Everything still in flight after this cycle belongs to the abandoned path.
            drop_nx  = out_nx;
            count_nx = '0;
            wr_nx    = '0;
            rd_nx    = '0;
        end
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_RUN;
                    pc_nx     = start_pc;
                    rsp_pc_nx = start_pc;
                end
            end
            S_RUN: begin
                if (halt_run) begin
                    state_nx = (out_nx == '0) ? S_IDLE : S_DRAIN;
                end else if (ext_redir) begin
                    pc_nx     = redirect_pc;
                    rsp_pc_nx = redirect_pc;
                end else if (jmp_hit) begin
                    pc_nx     = imem_rsp_data[PC_WIDTH-1:0];
                    rsp_pc_nx = imem_rsp_data[PC_WIDTH-1:0];
                end
            end
            S_DRAIN: begin
                if (out_nx == '0)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            rsp_pc      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            rsp_pc      <= rsp_pc_nx;
            outstanding <= out_nx;
            drop_cnt    <= drop_nx;
            count       <= count_nx;
            rd_ptr      <= rd_nx;
            wr_ptr      <= wr_nx;
        end
    end

    // Storage is cleared on reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_inst[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;
endmodule

// File: tb/tb_gpu_fetch_unit.sv
// Bench for gpu_fetch_unit: directed phases plus randomized traffic against an
// instruction-stream reference model and a latency-programmable memory model.
module tb_gpu_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt, redirect_valid;
    logic [15:0] start_pc, redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid, inst_ready, busy;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    gpu_fetch_unit #(.PC_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .busy(busy), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mq[$];
    logic [15:0] pop_log[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, epoch = 0, lat = 1, pops = 0;
    logic        running = 1'b0;
    logic [15:0] exp_pc = '0;
    logic        d_start = 0, d_halt = 0, d_redir = 0, d_iready = 1, d_qready = 1;
    logic [15:0] d_spc = '0, d_rpc = '0;
    logic        s_req_valid, s_inst_valid, s_busy;
    logic [15:0] s_req_addr;

    // Memory image: only address 0x0005 holds a JMP (to 0x0040).
    function automatic logic [31:0] word(input logic [15:0] a);
        logic [15:0] hi;
        logic [31:0] w;
        hi = (a * 16'h9e37) ^ 16'hc3a5;
        w  = {hi, a ^ 16'h1234};
        if (a == 16'h0005) w = 32'h7123_0040;
        else if (w[31:28] == 4'h7) w[31:28] = 4'h8;
        return w;
    endfunction

    // PC the decode stage should see next when the program flow reaches p.
    function automatic logic [15:0] norm(input logic [15:0] p);
        logic [15:0] q;
        q = p;
`ifdef GPU_FETCH_JMP_PREDECODE_EN
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = word(q);
            if (w[31:28] == 4'h7) q = w[15:0];
        end
`endif
        return q;
    endfunction

    function automatic int inflight();
        int n = 0;
        foreach (mq[i]) if (mq[i].epoch == epoch) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_req_addr"}, imem_req_addr, 0);
        chk({tag, "_inst_valid"}, inst_valid, 0);
        chk({tag, "_inst"}, inst, 0);
        chk({tag, "_inst_pc"}, inst_pc, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic step();
        int    nin;
        mreq_t m;
        @(negedge clk);
        start          = d_start;
        start_pc       = d_spc;
        halt           = d_halt;
        redirect_valid = d_redir;
        redirect_pc    = d_rpc;
        inst_ready     = d_iready;
        imem_req_ready = d_qready;
        nin            = inflight();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(m.addr);
        end
        #1;
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_busy       = busy;
        chk("busy", busy, running || nin > 0);
        if (!running) begin
            chk("idle_inst_valid", inst_valid, 0);
            chk("idle_req_valid", imem_req_valid, 0);
        end
        if (inst_valid && inst_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, word(exp_pc));
            pop_log.push_back(inst_pc);
            pops++;
            exp_pc = norm(16'(exp_pc + 16'd1));
        end
        if (imem_req_valid && imem_req_ready)
            mq.push_back('{imem_req_addr, cyc + lat, epoch});
        if (running && d_halt) running = 1'b0;
        else if (running && d_redir) exp_pc = norm(d_rpc);
        else if (!running && nin == 0 && d_start && rst_n) begin
            running = 1'b1;
            exp_pc  = norm(d_spc);
        end
        d_start = 0;
        d_halt  = 0;
        d_redir = 0;
        cyc++;
        @(posedge clk);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((busy || mq.size() > 0) && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, n < 200, 1);
    endtask

    task automatic wait_inflight(input int k, input string tag);
        int n = 0;
        while (inflight() < k && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, n < 50, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n = 0; start = 0; halt = 0; redirect_valid = 0; start_pc = '0; redirect_pc = '0;
        imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = '0; inst_ready = 1;
        repeat (3) step();
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1;

        // Start at 0x0010, latency 1, decode always ready.
        lat = 1;
        pop_log.delete();
        d_start = 1; d_spc = 16'h0010;
        step();
        step();
        chk("start_req_valid", s_req_valid, 1);
        chk("start_req_addr", s_req_addr, 16'h0010);
        repeat (6) step();
        p0 = pops;
        repeat (10) step();
        chk("throughput", pops - p0, 10);
        chk("seq_first_pc", pop_log[0], 16'h0010);
        chk("seq_third_pc", pop_log[2], 16'h0012);

        // Decode stall: credit limit must stop requests.
        d_iready = 0;
        repeat (10) step();
        chk("stall_req_valid", s_req_valid, 0);
        chk("stall_inst_valid", s_inst_valid, 1);
        d_iready = 1;
        repeat (15) step();

        // Latency 3, redirect with two requests in flight.
        lat = 3;
        d_qready = 0;
        repeat (5) step();
        d_qready = 1;
        repeat (2) step();
        pop_log.delete();
        d_redir = 1; d_rpc = 16'h0100;
        step();
        step();
        chk("redir_inst_valid", s_inst_valid, 0);
        chk("redir_req_valid", s_req_valid, 1);
        chk("redir_req_addr", s_req_addr, 16'h0100);
        repeat (12) step();
        chk("redir_first_pc", pop_log[0], 16'h0100);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            d_iready = ($urandom_range(0, 3) != 0);
            d_qready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                d_redir = 1;
                d_rpc   = 16'($urandom_range(16'h0100, 16'h7f00));
            end
            step();
        end

        // Halt with requests in flight: drain then idle.
        lat = 3; d_iready = 1; d_qready = 1;
        wait_inflight(3, "halt_fill");
        d_halt = 1;
        step();
        step();
        chk("halt_busy", s_busy, 1);
        chk("halt_inst_valid", s_inst_valid, 0);
        wait_quiet("halt_drain");
        chk("halt_idle_busy", s_busy, 0);

        // Asynchronous reset mid-run with responses still owed.
        d_start = 1; d_spc = 16'h0200;
        step();
        wait_inflight(2, "rst_fill");
        #2 rst_n = 0;
        #1 check_reset_vals("midrst");
        epoch++;
        running = 1'b0;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1;
        wait_quiet("midrst_stale");
        chk("midrst_busy", s_busy, 0);
        chk("midrst_inst_valid", s_inst_valid, 0);

        // JMP at 0x0005.
        lat = 1;
        pop_log.delete();
        d_start = 1; d_spc = 16'h0002;
        step();
        repeat (12) step();
        chk("jmp_pc_before", pop_log[2], 16'h0004);
`ifdef GPU_FETCH_JMP_PREDECODE_EN
        chk("jmp_pc_after", pop_log[3], 16'h0040);
        chk("jmp_pc_next", pop_log[4], 16'h0041);
`else
        chk("jmp_pc_after", pop_log[3], 16'h0005);
        chk("jmp_pc_next", pop_log[4], 16'h0006);
`endif
        d_halt = 1;
        step();
        wait_quiet("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpu_fetch_unit.md
# gpu_fetch_unit

Instruction fetch stage of the SIMT core. Issues word-addressed requests to instruction memory, buffers the returned 32-bit `instruction_t` words (opcode[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0]) in a small in-order queue, and presents them with their PC to the decode stage over a valid/ready handshake. It accepts PC redirects from branch resolution (BEQ/JMP) and discards stale in-flight responses.

## Interface
- `PC_WIDTH`, 16, PC and instruction-memory address width (word addressed).
- `FIFO_DEPTH`, 4, instruction queue entries; power of two, ≥2.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  pulse; begin fetching at `start_pc` (honoured in IDLE only).
- `start_pc`  in  PC_WIDTH  initial PC.
- `halt`  in  1  pulse; stop fetching, flush queue.
- `redirect_valid`  in  1  branch redirect.
- `redirect_pc`  in  PC_WIDTH  redirect target.
- `imem_req_valid`  out  1  request valid.
- `imem_req_addr`  out  PC_WIDTH  request word address.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response valid; responses return in request order, ≥1 cycle after acceptance, no backpressure.
- `imem_rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  queue head valid.
- `inst`  out  32  queue head, `instruction_t` layout.
- `inst_pc`  out  PC_WIDTH  PC of queue head.
- `inst_ready`  in  1  decode accepts head.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE; `pc`=0, counters 0, queue empty.
- IDLE: `start` → RUN, `pc`←`start_pc`. `redirect_valid` ignored.
- RUN: `imem_req_valid`=1 iff `fifo_count + outstanding < FIFO_DEPTH` (counts are registered values; no combinational path from `inst_ready`). `imem_req_addr`=`pc`. On handshake `pc`←`pc+1` (wraps modulo 2^PC_WIDTH), `outstanding`+1.
- Response with `drop_cnt`=0: pushed to queue with its PC; `outstanding`−1. Response with `drop_cnt`>0: discarded, `drop_cnt`−1, `outstanding`−1.
- Pop when `inst_valid && inst_ready`.
- Redirect (RUN): queue flushed; `pc`←`redirect_pc`; `drop_cnt`←requests in flight after this cycle (outstanding + accepted this cycle − response arriving this cycle, which is itself dropped). No request issued in the redirect cycle; issue resumes next cycle.
- Halt (RUN): priority over redirect and start. Queue flushed; if in-flight count after this cycle is 0 → IDLE, else DRAIN with `drop_cnt` set as for redirect.
- DRAIN: `imem_req_valid`=0; all responses dropped; → IDLE when `outstanding` reaches 0.
- Queue never overflows (credit rule); push and pop in same cycle legal at any occupancy.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `busy`=0.
- `start` at cycle T → `imem_req_valid`=1, addr=`start_pc` at T+1.
- Response at cycle T → `inst_valid` at T+1 if queue was empty (registered queue output).
- Redirect at T → `inst_valid`=0 at T+1; request to `redirect_pc` at T+1.
- Memory latency 1: sustained 1 instruction/cycle with `FIFO_DEPTH`≥4 and `inst_ready` held high.

## Configuration
- `GPU_FETCH_JMP_PREDECODE_EN` defined: non-dropped response with opcode JMP (4'b0111) is not pushed; treated as an internal redirect to `imm[PC_WIDTH-1:0]` (same flush/drop rules as `redirect_valid`; external redirect in same cycle wins).
- Undefined: JMP is pushed like any instruction; redirect comes only from `redirect_valid`.

## Test plan
- Reset mid-RUN with 2 outstanding → all outputs at reset values next cycle; later responses ignored, `busy`=0.
- `start_pc`=0x0010, memory latency 1, `inst_ready`=1 → `inst_pc` 0x0010, 0x0011, 0x0012… on consecutive cycles, `inst` matches memory.
- `inst_ready`=0 for 10 cycles → `imem_req_valid` drops after queue+outstanding=4; no loss or duplication when released.
- Latency 3, redirect to 0x0100 with 2 outstanding → those 2 responses dropped; next `inst_pc`=0x0100.
- `halt` with 3 outstanding → DRAIN, `busy` stays 1 until third response, then IDLE; `inst_valid`=0 throughout.
- Macro defined, JMP imm=0x0040 at 0x0005 → decode sees 0x0004 then 0x0040; undefined → sees 0x0005 (JMP) then 0x0006.
